jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Drives a bank of WIDTH external JK flip-flops to a requested target value.
- Per bit, derives J/K excitation from the current flop state (q_fb) and the target, then checks the flops after they update.
- Retries on mismatch and reports success or failure through a single-cycle response.
- This is the controller side of the J/K interface: it produces J/K and consumes Q. It sits between a register-write requester and a JK flop bank.

Parameters:
- WIDTH, 8, number of JK flops driven.
- MAX_RETRY, 3, extra drive attempts allowed after the first attempt fails.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_target  input  WIDTH  desired flop values.
- req_mask  input  WIDTH  1 = bit is updated and checked; 0 = bit is held and ignored.
- q_fb  input  WIDTH  Q outputs of the flop bank.
- J  output  WIDTH  J inputs to the flop bank.
- K  output  WIDTH  K inputs to the flop bank.
- busy  output  1  high in any state other than IDLE.
- resp_valid  output  1  single-cycle response strobe.
- resp_err  output  1  qualified by resp_valid; 1 = target not reached.
- resp_attempts  output  $clog2(MAX_RETRY+2)  qualified by resp_valid; drive cycles used.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset: state goes to IDLE and every output is 0, including req_ready.
  - req_ready rises in the first clk edge after rst_n deasserts.
  - Reset mid-operation aborts immediately: J/K return to 0 and no response is issued.
- State machine: IDLE -> DRIVE -> CHECK -> (DRIVE | RESP) -> IDLE.
- IDLE: req_ready=1, J=K=0.
  - On req_valid && req_ready (cycle N): latch target and mask.
  - Attempt counter = 1.
  - Compute registered J/K from q_fb in cycle N.
  - Next state DRIVE.
- DRIVE (cycle N+1): J/K held for exactly one cycle; the flops sample them at the end of the cycle. Next state CHECK.
- CHECK (cycle N+2): J=K=0. Compare q_fb against the target on masked bits only.
  - Match: next state RESP, err=0.
  - Mismatch and attempts <= MAX_RETRY: recompute J/K from the current q_fb, increment attempts, go to DRIVE.
  - Mismatch and attempts = MAX_RETRY+1: next state RESP, err=1.
- RESP (cycle N+3 on first-try success): resp_valid=1 for one cycle with resp_err and resp_attempts valid. Next state IDLE.
- resp_valid, resp_err and resp_attempts are 0 outside RESP.
- Excitation per masked bit, default encoding (don't-cares driven 0):
  - Q 0->0: J=0, K=0.
  - Q 0->1: J=1, K=0.
  - Q 1->0: J=0, K=1.
  - Q 1->1: J=0, K=0.
- Unmasked bits always get J=K=0 (hold).
- J=K=1 is never driven in default encoding.
- Minimum request-to-request spacing is 4 cycles; req_ready=0 from DRIVE through RESP.
- req_mask=0: full sequence still runs with J=K=0; response err=0, attempts=1.
- req_valid while busy is ignored; the requester must hold it until accepted.
- Only registered state drives outputs; there is no combinational path from q_fb to J/K.

Optional Feature:
- Macro: JK_BANK_DRIVER_TOGGLE_EN.
- Defined: masked bits use toggle encoding.
  - Change (0->1 or 1->0): J=K=1.
  - No change: J=K=0.
  - Check, retry and response behaviour are unchanged.
- Undefined: default set/reset encoding above; J and K are never both 1.

Test Plan:
- Reset: hold rst_n=0, then release.
  - While rst_n=0: J=K=0, req_ready=0, resp_valid=0, busy=0.
  - req_ready=1 one cycle after release.
- Basic write: q_fb=8'h00, target=8'hA5, mask=8'hFF, flop model responsive.
  - DRIVE cycle: J=8'hA5, K=8'h00.
  - RESP at N+3: err=0, attempts=1.
- Mixed write: q_fb=8'hF0, target=8'h3C, mask=8'hFF.
  - DRIVE: J=8'h0C, K=8'hC0.
  - With TOGGLE_EN: J=K=8'hCC.
- Mask: q_fb=8'hFF, target=8'h00, mask=8'h0F.
  - DRIVE: J=8'h00, K=8'h0F.
  - Upper nibble of q_fb stays 8'hF_.
  - err=0.
- Stuck bit: flop model holds bit 3 at 0, target=8'h08, mask=8'h08, MAX_RETRY=3.
  - Four DRIVE cycles, each with J=8'h08.
  - RESP err=1, attempts=4.
- Reset mid-operation: assert rst_n=0 during CHECK.
  - J=K=0 immediately, no resp_valid.
  - After release, a new request completes normally.

Source files
------------

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives a JK flop bank to a target value with check and retry.
// Optional macro JK_BANK_DRIVER_TOGGLE_EN selects toggle encoding on masked bits.
module jk_bank_driver #(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 3,
   localparam int AW       = $clog2(MAX_RETRY + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_target,
   input  logic [WIDTH-1:0] req_mask,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy,
   output logic             resp_valid,
   output logic             resp_err,
   output logic [AW-1:0]    resp_attempts
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [AW-1:0]    att_q, att_d;
   logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
   logic             ready_q, ready_d;
   logic             rv_q, rv_d, re_q, re_d;
   logic [AW-1:0]    ra_q, ra_d;

`ifdef JK_BANK_DRIVER_TOGGLE_EN
   function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q, t, m);
      return m & (q ^ t);
   endfunction
   function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q, t, m);
      return m & (q ^ t);
   endfunction
`else
   function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q, t, m);
      return m & ~q & t;
   endfunction
   function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q, t, m);
      return m & q & ~t;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      mask_d   = mask_q;
      att_d    = att_q;
      j_d      = '0;
      k_d      = '0;
      rv_d     = 1'b0;
      re_d     = 1'b0;
      ra_d     = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               target_d = req_target;
               mask_d   = req_mask;
               att_d    = AW'(1);
               j_d      = excite_j(q_fb, req_target, req_mask);
               k_d      = excite_k(q_fb, req_target, req_mask);
               state_d  = DRIVE;
            end
         end
         DRIVE: state_d = CHECK;
         CHECK: begin
            if (((q_fb ^ target_q) & mask_q) == '0) begin
               state_d = RESP;
               rv_d    = 1'b1;
               ra_d    = att_q;
            end else if (att_q <= AW'(MAX_RETRY)) begin
               // Re-derive excitation from the flops as they are now, not as first seen.
               j_d     = excite_j(q_fb, target_q, mask_q);
               k_d     = excite_k(q_fb, target_q, mask_q);
               att_d   = att_q + AW'(1);
               state_d = DRIVE;
            end else begin
               state_d = RESP;
               rv_d    = 1'b1;
               re_d    = 1'b1;
               ra_d    = att_q;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         mask_q   <= '0;
         att_q    <= '0;
         j_q      <= '0;
         k_q      <= '0;
         ready_q  <= 1'b0;
         rv_q     <= 1'b0;
         re_q     <= 1'b0;
         ra_q     <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         mask_q   <= mask_d;
         att_q    <= att_d;
         j_q      <= j_d;
         k_q      <= k_d;
         ready_q  <= ready_d;
         rv_q     <= rv_d;
         re_q     <= re_d;
         ra_q     <= ra_d;
      end
   end

   assign J             = j_q;
   assign K             = k_q;
   assign req_ready     = ready_q;
   assign busy          = (state_q != IDLE);
   assign resp_valid    = rv_q;
   assign resp_err      = re_q;
   assign resp_attempts = ra_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - randomized self-checking bench for jk_bank_driver.
module tb_jk_bank_driver;
   localparam int W  = 8;
   localparam int MR = 3;
   localparam int AW = $clog2(MR + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  req_target = '0;
   logic [W-1:0]  req_mask = '0;
   logic [W-1:0]  J, K;
   logic          busy, resp_valid, resp_err;
   logic [AW-1:0] resp_attempts;

   logic [W-1:0]  fq = '0;
   logic [W-1:0]  stuck0 = '0;
   logic          load_en = 1'b0;
   logic [W-1:0]  load_val = '0;

   int pass_cnt = 0;
   int total = 0;

   jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_target(req_target), .req_mask(req_mask), .q_fb(fq), .J(J), .K(K),
      .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_attempts(resp_attempts)
   );

   always #5 clk = ~clk;

   // External flop bank: JK characteristic equation, with optional stuck-at-0 bits.
   always @(posedge clk) begin
      if (load_en) fq <= load_val & ~stuck0;
      else         fq <= ((J & ~fq) | (~K & fq)) & ~stuck0;
   end

   // Reference excitation, bit by bit from the truth table.
   function automatic void ref_exc(input logic [W-1:0] q, t, m, output logic [W-1:0] j, k);
      j = '0; k = '0;
      for (int b = 0; b < W; b++) begin
         if (m[b] && (q[b] != t[b])) begin
`ifdef JK_BANK_DRIVER_TOGGLE_EN
            j[b] = 1'b1; k[b] = 1'b1;
`else
            if (t[b]) j[b] = 1'b1; else k[b] = 1'b1;
`endif
         end
      end
   endfunction

   function automatic logic [W-1:0] ref_apply(input logic [W-1:0] q, j, k, s);
      logic [W-1:0] r;
      r = q;
      for (int b = 0; b < W; b++) begin
         case ({j[b], k[b]})
            2'b10: r[b] = 1'b1;
            2'b01: r[b] = 1'b0;
            2'b11: r[b] = ~q[b];
            default: r[b] = q[b];
         endcase
      end
      return r & ~s;
   endfunction

   task automatic preload(input logic [W-1:0] v, input logic [W-1:0] s);
      @(negedge clk);
      stuck0 = s; load_val = v; load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (req_ready !== 1'b1) $display("FAIL %s ready_timeout got=%b want=1", name, req_ready);
      else pass_cnt++;
   endtask

   task automatic run_req(input logic [W-1:0] t, input logic [W-1:0] m, input string name);
      logic [W-1:0] ej[MR+1], ek[MR+1];
      logic [W-1:0] q, jj, kk;
      int           na;
      logic         err;
      logic [2*W+4+AW-1:0] got, exp;
      q = fq; na = 0; err = 1'b1;
      for (int a = 0; a <= MR; a++) begin
         ref_exc(q, t, m, jj, kk);
         ej[a] = jj; ek[a] = kk;
         q = ref_apply(q, jj, kk, stuck0);
         na = a + 1;
         if (((q ^ t) & m) == '0) begin err = 1'b0; break; end
      end
      wait_ready(name);
      req_valid = 1'b1; req_target = t; req_mask = m;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= 2 * na + 2; c++) begin
         got = {J, K, busy, req_ready, resp_valid, resp_err, resp_attempts};
         if (c == 2 * na + 2)      exp = {{2*W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, {AW{1'b0}}};
         else if (c == 2 * na + 1) exp = {{2*W{1'b0}}, 1'b1, 1'b0, 1'b1, err, AW'(na)};
         else if (c % 2 == 1)      exp = {ej[(c-1)/2], ek[(c-1)/2], 1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}};
         else                      exp = {{2*W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}};
         total++;
         if (got !== exp)
            $display("FAIL %s cycle%0d {J,K,busy,ready,rv,err,att} got=%h want=%h", name, c, got, exp);
         else pass_cnt++;
`ifndef JK_BANK_DRIVER_TOGGLE_EN
         total++;
         if ((J & K) !== '0) $display("FAIL %s cycle%0d j_and_k got=%h want=00", name, c, J & K);
         else pass_cnt++;
`endif
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({J, K, req_ready, resp_valid, busy} !== '0)
         $display("FAIL reset_hold got=%h want=0", {J, K, req_ready, resp_valid, busy});
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b0) $display("FAIL reset_ready_early got=%b want=0", req_ready);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready_rise got=%b want=1", req_ready);
      else pass_cnt++;
   endtask

   task automatic test_directed();
      preload(8'h00, 8'h00);
      run_req(8'hA5, 8'hFF, "basic");
      preload(8'hF0, 8'h00);
      run_req(8'h3C, 8'hFF, "mixed");
      preload(8'hFF, 8'h00);
      run_req(8'h00, 8'h0F, "mask");
      total++;
      if (fq[7:4] !== 4'hF) $display("FAIL mask_upper got=%h want=f", fq[7:4]);
      else pass_cnt++;
      preload(8'h5A, 8'h00);
      run_req(8'hC3, 8'h00, "mask_zero");
      preload(8'h00, 8'h08);
      run_req(8'h08, 8'h08, "stuck");
   endtask

   task automatic test_reset_midop();
      logic [W-1:0] snap;
      preload(8'h00, 8'h08);
      for (int ph = 1; ph <= 2; ph++) begin
         wait_ready("midop");
         req_valid = 1'b1; req_target = 8'h0F; req_mask = 8'hFF;
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         if (ph == 2) @(negedge clk);
         #1 rst_n = 1'b0;
         #1;
         total++;
         if ({J, K, busy, resp_valid, req_ready} !== '0)
            $display("FAIL midop_ph%0d_immediate got=%h want=0", ph, {J, K, busy, resp_valid, req_ready});
         else pass_cnt++;
         snap = fq;
         repeat (3) begin
            @(negedge clk);
            total++;
            if ({resp_valid, busy, J, K} !== '0 || fq !== snap)
               $display("FAIL midop_ph%0d_held got=%h want=0", ph, {resp_valid, busy, J, K});
            else pass_cnt++;
         end
         rst_n = 1'b1;
      end
      preload(8'h00, 8'h00);
      run_req(8'h3C, 8'hFF, "after_reset");
   endtask

   task automatic test_random();
      logic [W-1:0] s;
      for (int i = 0; i < 25; i++) begin
         s = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W-1)) : '0;
         preload(W'($urandom), s);
         run_req(W'($urandom), W'($urandom), "random");
      end
      stuck0 = '0;
   endtask

   task automatic test_back_to_back();
      preload(8'h00, 8'h00);
      for (int i = 0; i < 4; i++) run_req(W'($urandom), 8'hFF, "b2b");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_midop();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
endmodule
